// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU issue stage: opcodes, instruction
// field positions, FSM states and flag bit indices.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_SLT = 4'h8;
  localparam logic [3:0] OP_LDI = 4'hF;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 8;
  localparam int RS2_HI = 7;
  localparam int RS2_LO = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_V = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_SLT;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered ready and occupancy count.
// Pushes are gated internally by ready, pops by non-empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     ready_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             ready_q;
  logic             push, pop;

  assign push    = push_i && ready_q;
  assign pop     = pop_i && (count_q != '0);
  assign dout_o  = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign ready_o = ready_q;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
  end

  // ready is registered from the next count so it tracks count < DEPTH exactly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      count_q <= count_d;
      ready_q <= (count_d != CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage around the external 8-bit ALU: instruction FIFO,
// 4x8 register file, flag register and an IDLE/ISSUE/WB sequencer.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic        alu_overflow,
  input  logic        alu_negative,
  input  logic        alu_zero,
  output logic [2:0]  flags,
  output logic        wb_valid,
  output logic [1:0]  wb_rd,
  output logic        busy,
  output logic        err,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);
  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       instr_q;
  logic [15:0]       fifo_dout;
  logic              fifo_empty, fifo_pop;
  logic [AW:0]       fifo_count;
  logic [3:0][7:0]   rf_q;
  logic [7:0]        alu_a_q, alu_b_q;
  logic [3:0]        alu_op_q;
  logic [2:0]        flags_q;
  logic              err_q;

  logic [3:0] opc;
  logic [1:0] rd, rs1, rs2;
  assign opc = instr_q[OPC_HI:OPC_LO];
  assign rd  = instr_q[RD_HI:RD_LO];
  assign rs1 = instr_q[RS1_HI:RS1_LO];
  assign rs2 = instr_q[RS2_HI:RS2_LO];

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .din_i   (in_instr),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .ready_o (in_ready),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WB;
      S_WB:    state_d = fifo_empty ? S_IDLE : S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop = (state_q == S_IDLE || state_q == S_WB) && !fifo_empty;
    wb_valid = (state_q == S_WB);
    busy     = (state_q != S_IDLE) || (fifo_count != '0);
  end

  // Operands are read in ISSUE, one edge after the previous WB write lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q  <= '0;
      rf_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_ADD;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (fifo_pop) instr_q <= fifo_dout;
      if (state_q == S_ISSUE) begin
        if (is_alu_op(opc)) begin
          alu_a_q  <= rf_q[rs1];
          alu_b_q  <= rf_q[rs2];
          alu_op_q <= opc;
        end else begin
          alu_op_q <= OP_ADD;
        end
      end
      if (state_q == S_WB) begin
        if (is_alu_op(opc)) begin
          rf_q[rd]       <= alu_result;
          flags_q[FLG_V] <= alu_overflow;
          flags_q[FLG_N] <= alu_negative;
          flags_q[FLG_Z] <= alu_zero;
        end else if (opc == OP_LDI) begin
          rf_q[rd] <= instr_q[IMM_HI:IMM_LO];
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign flags    = flags_q;
  assign err      = err_q;
  assign wb_rd    = rd;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural ALU on the feedback path,
// instruction-level reference model, directed table plus random batches.
module tb_alu_issue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_overflow, alu_negative, alu_zero;
  logic [2:0]  flags;
  logic        wb_valid, busy, err;
  logic [1:0]  wb_rd;
  logic [1:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;

  int checks = 0;
  int errors = 0;
  int rdy_low = 0;

  logic [7:0] m_reg [4];
  logic [2:0] m_flags;
  logic       m_err;
  int         exp_wb [$];
  int         got_wb [$];

  always #5 clk = ~clk;

  alu_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .flags(flags),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .busy(busy), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Returns {overflow, negative, zero, result}
  function automatic logic [10:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic v;
    v = 1'b0;
    case (op)
      4'd0: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << 1;
      4'd7: r = a >> 1;
      4'd8: r = (a < b) ? 8'd1 : 8'd0;
      default: r = 8'd0;
    endcase
    return {v, r[7], (r == 8'd0), r};
  endfunction

  always_comb {alu_overflow, alu_negative, alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b);

  always @(negedge clk) begin
    if (rst_n && wb_valid) got_wb.push_back(int'(wb_rd));
    if (!in_ready) rdy_low++;
  end

  function automatic void m_apply(input logic [15:0] ins);
    logic [3:0] op;
    logic [10:0] r;
    op = ins[15:12];
    if (op <= 4'd8) begin
      r = alu_f(op, m_reg[ins[9:8]], m_reg[ins[7:6]]);
      m_reg[ins[11:10]] = r[7:0];
      m_flags = r[10:8];
    end else if (op == 4'hF) begin
      m_reg[ins[11:10]] = ins[7:0];
    end else begin
      m_err = 1'b1;
    end
    exp_wb.push_back(int'(ins[11:10]));
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_flags = 3'b000;
    m_err = 1'b0;
    exp_wb.delete();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] ins);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      m_apply(ins);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_all(input string tag);
    int n;
    for (int r = 0; r < 4; r++) begin
      dbg_addr = 2'(r);
      #1;
      chk($sformatf("%s_reg%0d", tag, r), 32'(dbg_data), 32'(m_reg[r]));
    end
    chk({tag, "_flags"}, 32'(flags), 32'(m_flags));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_wb_cnt"}, 32'(got_wb.size()), 32'(exp_wb.size()));
    n = (got_wb.size() < exp_wb.size()) ? got_wb.size() : exp_wb.size();
    for (int i = 0; i < n; i++)
      if (got_wb[i] != exp_wb[i]) begin
        chk($sformatf("%s_wb_rd%0d", tag, i), 32'(got_wb[i]), 32'(exp_wb[i]));
        break;
      end
    got_wb.delete();
    exp_wb.delete();
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [1:0]  rd;
    logic [7:0]  val;
    logic [2:0]  flg;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{16'hF405, 2'd1, 8'h05, 3'b000};  // LDI R1,05
    tbl[1] = '{16'hF803, 2'd2, 8'h03, 3'b000};  // LDI R2,03
    tbl[2] = '{16'h0D80, 2'd3, 8'h08, 3'b000};  // ADD R3,R1,R2
    tbl[3] = '{16'hF47F, 2'd1, 8'h7F, 3'b000};  // LDI R1,7F
    tbl[4] = '{16'hF801, 2'd2, 8'h01, 3'b000};  // LDI R2,01
    tbl[5] = '{16'h0180, 2'd0, 8'h80, 3'b110};  // ADD R0,R1,R2
    tbl[6] = '{16'hF422, 2'd1, 8'h22, 3'b110};  // LDI R1,22 keeps flags
    tbl[7] = '{16'h1940, 2'd2, 8'h00, 3'b001};  // SUB R2,R1,R1
    tbl[8] = '{16'h8E40, 2'd3, 8'h01, 3'b000};  // SLT R3,R2,R1

    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    check_all("rst");

    // Latency: push at edge N -> ISSUE N+1, WB N+2, visible N+3
    in_valid = 1'b1;
    in_instr = 16'hF0A5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    m_apply(16'hF0A5);
    @(negedge clk);
    chk("lat_idle_wb", 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk("lat_issue_wb", 32'(wb_valid), 32'd1 - 32'd1);
    dbg_addr = 2'd0;
    @(negedge clk);
    chk("lat_wb_valid", 32'(wb_valid), 32'd1);
    chk("lat_wb_rd", 32'(wb_rd), 32'd0);
    chk("lat_pre_write", 32'(dbg_data), 32'h00);
    @(negedge clk);
    chk("lat_post_write", 32'(dbg_data), 32'hA5);
    chk("lat_wb_drop", 32'(wb_valid), 32'd0);
    check_all("lat");

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].instr);
      wait_idle();
      dbg_addr = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_val", i), 32'(dbg_data), 32'(tbl[i].val));
      chk($sformatf("tbl%0d_flags", i), 32'(flags), 32'(tbl[i].flg));
    end
    check_all("tbl");

    rdy_low = 0;
    for (int i = 0; i < 8; i++)
      send(16'hF000 | 16'((i % 4) << 10) | 16'(8'h30 + i));
    wait_idle();
    chk("full_ready_dropped", 32'(rdy_low > 0), 32'd1);
    check_all("full");

    send(16'hF85A);
    send(16'hA800);
    wait_idle();
    chk("rsv_err", 32'(err), 32'd1);
    dbg_addr = 2'd2;
    #1 chk("rsv_r2", 32'(dbg_data), 32'h5A);
    send(16'h0680);
    wait_idle();
    chk("rsv_err_sticky", 32'(err), 32'd1);
    check_all("rsv");

    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 12; i++) begin
        send({4'($urandom_range(0, 15)), 12'($urandom)});
        if ($urandom_range(0, 3) == 0) repeat (2) @(negedge clk);
      end
      wait_idle();
      check_all($sformatf("rnd%0d", b));
    end

    // Reset during WB of ADD R3,R1,R2 with two instructions queued
    send(16'hF405);
    send(16'hF803);
    wait_idle();
    check_all("pre_rst");
    send(16'h0D80);
    send(16'hF001);
    send(16'hF002);
    begin
      int t;
      t = 0;
      while (!(wb_valid && wb_rd == 2'd3) && t < 10) begin
        @(negedge clk);
        t++;
      end
      chk("rst_mid_wb_reached", 32'(wb_valid && wb_rd == 2'd3), 32'd1);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
    got_wb.delete();
    @(negedge clk);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);
    check_all("rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Instruction issue and writeback stage for the 8-bit ALU. Accepts 16-bit instructions over a valid/ready interface and buffers them in a small FIFO. It reads operands from a 4-entry, 8-bit register file and drives the ALU's A/B/opcode inputs from registers. On the following cycle it captures the ALU result and flags back into the register file and a flag register. The ALU's combinational output feeds straight back into this block, so the block sits immediately upstream and downstream of the ALU.

## Interface
- DEPTH, 4, instruction FIFO depth (power of two, ≥2)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  FIFO can accept; high when count < DEPTH
- in_instr  in  16  [15:12] opcode, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm (LDI only)
- alu_a, alu_b  out  8 each  registered ALU operands
- alu_op  out  4  registered ALU opcode
- alu_result  in  8  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_overflow, alu_negative, alu_zero  in  1 each  ALU flags
- flags  out  3  {overflow, negative, zero}, registered
- wb_valid  out  1  one-cycle pulse when an instruction retires
- wb_rd  out  2  destination of the retiring instruction (valid with wb_valid)
- busy  out  1  high when FSM ≠ IDLE or FIFO non-empty
- err  out  1  sticky; set on a reserved opcode, cleared only by reset
- dbg_addr  in  2  register file debug read address
- dbg_data  out  8  combinational read of reg[dbg_addr]

## Operation
- Opcodes 0000–1000 are ALU ops: ADD, SUB, AND, OR, XOR, NOT A, SHL, SHR, SLT (unsigned A<B gives 1).
- Opcode 1111 is LDI: reg[rd] = imm. The ALU is not used and flags are unchanged.
- Opcodes 1001–1110 are reserved: no register write, flags unchanged, err set. The instruction still retires with wb_valid.
- FIFO: a push occurs when in_valid && in_ready. A pop occurs on entry to ISSUE. There is no bypass: a push into an empty FIFO is visible to the FSM the next cycle. A push while full is ignored (in_ready is low).
- FSM states: IDLE, ISSUE, WB.
  - IDLE → ISSUE when the FIFO is non-empty. Pop the head into instr_q.
  - ISSUE: alu_a ← reg[rs1], alu_b ← reg[rs2], alu_op ← opcode. For LDI or reserved opcodes, alu_op ← 0000 and the operands are don't-care. Then → WB.
  - WB: for ALU ops, reg[rd] ← alu_result and flags ← {alu_overflow, alu_negative, alu_zero}. wb_valid = 1. Then → ISSUE if the FIFO is non-empty (pop), else IDLE.
- Operands are read in ISSUE, after the previous WB write has landed. A back-to-back RAW dependency therefore needs no forwarding.
- All arithmetic is 8-bit and owned by the ALU. This block performs no arithmetic apart from the FIFO pointers and count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.

## Timing
- Throughput: one instruction per 2 cycles when the FIFO stays non-empty.
- Latency: a push at edge N gives ISSUE at N+1 (FIFO empty, FSM IDLE), WB at N+2, and reg/flags visible at N+3. wb_valid is high during the WB cycle.
- Simultaneous push and pop in the same cycle: count unchanged, both take effect.
- in_ready is a registered function of count. It may drop on the cycle the FIFO reaches DEPTH.
- Reset values (rst_n low at a rising edge): FIFO empty, count 0, FSM IDLE, every register 0, flags 000, alu_a/alu_b 00, alu_op 0000, wb_valid 0, err 0, in_ready 1 from the first cycle after reset.
- Reset asserted mid-ISSUE or mid-WB aborts the instruction: no write occurs and all queued instructions are discarded.

## Structure
- Shared package alu_pkg:
  - opcode constants (OP_ADD…OP_SLT, OP_LDI)
  - field positions of the instruction word
  - FSM state enum
  - flag index constants
- The ALU's own opcode encoding is imported from the same package.
- Sub-module sync_fifo (parameterised width and depth, count output) holds the instruction buffer. The FSM, register file and flag register live in alu_issue.

## Test plan
- LDI R1,0x05; LDI R2,0x03; ADD R3,R1,R2 → R3 = 0x08, flags 000, three wb_valid pulses, wb_rd = 3 on the last.
- LDI R1,0x7F; LDI R2,0x01; ADD R0,R1,R2 → R0 = 0x80, flags 110.
- LDI R1,0x22; SUB R2,R1,R1 → R2 = 0x00, flags 001. Then SLT R3,R2,R1 → R3 = 0x01, flags 000.
- Hold in_valid for 8 cycles with DEPTH = 4 → in_ready drops once 4 instructions are queued. All 8 instructions eventually retire in order and none is lost.
- Opcode 1010 with rd = 2 → R2 unchanged, flags unchanged, err = 1 and stays 1 through later valid instructions.
- Reset pulsed during the WB of an ADD with 2 instructions queued → after reset all registers are 0, busy = 0, and no wb_valid follows.
